// File: rtl/gfx_pkg.sv
// Shared graphics constants for the sprite pixel path: scan geometry,
// entity-code layout, orientation codes and the sprite colour palette.
package gfx_pkg;

  localparam int UPSCALE_FACTOR = 5;    // screen pixels per sprite texel
  localparam int TILE_SIZE      = 8;    // texels per tile edge
  localparam int H_ACTIVE       = 640;  // visible pixels per line
  localparam int V_ACTIVE       = 480;  // visible lines per frame

  localparam logic [8:0] ENTITY_NONE = 9'h1FF;

  // Scan-counter-width forms of the geometry, so compares stay width-exact
  localparam logic [9:0] H_ACTIVE_W = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACTIVE_W = 10'(V_ACTIVE);
  localparam logic [2:0] SUB_LAST   = 3'(UPSCALE_FACTOR - 1);
  localparam logic [2:0] COL_LAST   = 3'(TILE_SIZE - 1);

  typedef enum logic [1:0] {
    ORI_UP    = 2'b00,
    ORI_RIGHT = 2'b01,
    ORI_DOWN  = 2'b10,
    ORI_LEFT  = 2'b11
  } orient_e;

  // Entity code layout: {row[8:6], id[5:2], orient[1:0]}
  function automatic logic [2:0] ent_row(input logic [8:0] e);
    return e[8:6];
  endfunction

  function automatic logic [3:0] ent_id(input logic [8:0] e);
    return e[5:2];
  endfunction

  function automatic orient_e ent_orient(input logic [8:0] e);
    return orient_e'(e[1:0]);
  endfunction

  // RGB222 colour per sprite ID
  localparam logic [5:0] PALETTE [16] = '{
    6'h3F, 6'h30, 6'h0C, 6'h03, 6'h3C, 6'h33, 6'h0F, 6'h2A,
    6'h15, 6'h38, 6'h0E, 6'h23, 6'h1B, 6'h26, 6'h39, 6'h07
  };

endpackage

// File: rtl/sprite_rom.sv
// 1bpp sprite texture store: 16 IDs x 8 rows x 8 texels, combinational read.
// Each row is a byte whose MSB is texel column 0.
module sprite_rom #(
  parameter logic [1023:0] ROM_INIT = {128{8'b0011_1100}}
) (
  input  logic [3:0] i_id,
  input  logic [2:0] i_row,
  input  logic [2:0] i_col,
  output logic       o_texel
);

  logic [9:0] w_rom_idx;

  // Column 0 sits in bit 7 of each row byte, hence the inverted column
  assign w_rom_idx = {i_id, i_row, ~i_col};
  assign o_texel   = ROM_INIT[w_rom_idx];

endmodule

// File: rtl/sprite_pixel_renderer.sv
// Sprite pixel renderer: turns the per-pixel entity code and scan counters
// into an RGB222 sprite pixel stream with a fixed 2-cycle latency.
// Optional feature macro: SPRITE_ROTATE_EN enables the 90/270 degree
// orientations; without it only upright and 180 degree are applied.
module sprite_pixel_renderer
  import gfx_pkg::*;
#(
  parameter logic [1023:0] ROM_INIT = {128{8'b0011_1100}}
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] entity_in,
  input  logic [9:0] counter_H,
  input  logic [9:0] counter_V,
  output logic [5:0] pixel_colour,
  output logic       pixel_opaque,
  output logic       pixel_valid,
  output logic [9:0] counter_H_out
);

  logic [2:0] r_sub_cnt;
  logic [2:0] r_col_cnt;
  logic       r_sync_ok;

  logic       w_h_zero;
  logic       w_h_active;
  logic       w_v_active;
  logic [2:0] w_col_p0;
  logic       w_vld_p0;

  logic [2:0] r_row_p1;
  logic [3:0] r_id_p1;
  orient_e    r_ori_p1;
  logic [2:0] r_col_p1;
  logic       r_none_p1;
  logic       r_vld_p1;
  logic [9:0] r_hcnt_p1;

  logic [2:0] w_tex_r;
  logic [2:0] w_tex_c;
  logic       w_texel;
  logic       w_opaque;

  assign w_h_zero   = (counter_H == 10'd0);
  assign w_h_active = (counter_H < H_ACTIVE_W);
  assign w_v_active = (counter_V < V_ACTIVE_W);
  // The first pixel of a line uses column 0 directly and also counts as synced
  assign w_col_p0   = w_h_zero ? 3'd0 : r_col_cnt;
  assign w_vld_p0   = (r_sync_ok | w_h_zero) & w_h_active & w_v_active;

  // Divider-free texel column tracking, resynchronised at every line start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sub_cnt <= 3'd0;
      r_col_cnt <= 3'd0;
      r_sync_ok <= 1'b0;
    end else if (w_h_zero) begin
      r_sub_cnt <= 3'd1;
      r_col_cnt <= 3'd0;
      r_sync_ok <= 1'b1;
    end else if (!w_h_active) begin
      r_sub_cnt <= 3'd0;
      r_col_cnt <= 3'd0;
    end else if (r_sub_cnt == SUB_LAST) begin
      r_sub_cnt <= 3'd0;
      r_col_cnt <= (r_col_cnt == COL_LAST) ? 3'd0 : r_col_cnt + 3'd1;
    end else begin
      r_sub_cnt <= r_sub_cnt + 3'd1;
    end
  end

  // ---- stage 0 -> 1: capture decoded entity fields, column and validity ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row_p1  <= 3'd0;
      r_id_p1   <= 4'd0;
      r_ori_p1  <= ORI_UP;
      r_col_p1  <= 3'd0;
      r_none_p1 <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_hcnt_p1 <= 10'd0;
    end else begin
      r_row_p1  <= ent_row(entity_in);
      r_id_p1   <= ent_id(entity_in);
      r_ori_p1  <= ent_orient(entity_in);
      r_col_p1  <= w_col_p0;
      r_none_p1 <= (entity_in == ENTITY_NONE);
      r_vld_p1  <= w_vld_p0;
      r_hcnt_p1 <= counter_H;
    end
  end

  // Map screen-space (row, col) to texture-space (r, c) for the orientation
  always_comb begin
    w_tex_r = r_row_p1;
    w_tex_c = r_col_p1;
`ifdef SPRITE_ROTATE_EN
    case (r_ori_p1)
      ORI_UP: begin
        w_tex_r = r_row_p1;
        w_tex_c = r_col_p1;
      end
      ORI_RIGHT: begin
        w_tex_r = COL_LAST - r_col_p1;
        w_tex_c = r_row_p1;
      end
      ORI_DOWN: begin
        w_tex_r = COL_LAST - r_row_p1;
        w_tex_c = COL_LAST - r_col_p1;
      end
      ORI_LEFT: begin
        w_tex_r = r_col_p1;
        w_tex_c = COL_LAST - r_row_p1;
      end
      default: begin
        w_tex_r = r_row_p1;
        w_tex_c = r_col_p1;
      end
    endcase
`else
    // Only the 180 degree flip is kept; the transposing codes render upright
    case (r_ori_p1)
      ORI_DOWN: begin
        w_tex_r = COL_LAST - r_row_p1;
        w_tex_c = COL_LAST - r_col_p1;
      end
      ORI_UP, ORI_RIGHT, ORI_LEFT: begin
        w_tex_r = r_row_p1;
        w_tex_c = r_col_p1;
      end
      default: begin
        w_tex_r = r_row_p1;
        w_tex_c = r_col_p1;
      end
    endcase
`endif
  end

  sprite_rom #(
    .ROM_INIT (ROM_INIT)
  ) u_rom (
    .i_id    (r_id_p1),
    .i_row   (w_tex_r),
    .i_col   (w_tex_c),
    .o_texel (w_texel)
  );

  assign w_opaque = w_texel & ~r_none_p1 & r_vld_p1;

  // ---- stage 1 -> 2: resolve opacity and colour onto the output pixel ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_colour  <= 6'd0;
      pixel_opaque  <= 1'b0;
      pixel_valid   <= 1'b0;
      counter_H_out <= 10'd0;
    end else begin
      pixel_colour  <= w_opaque ? PALETTE[r_id_p1] : 6'd0;
      pixel_opaque  <= w_opaque;
      pixel_valid   <= r_vld_p1;
      counter_H_out <= r_hcnt_p1;
    end
  end

endmodule
